reg_dump_ctrl: RTL
==================

Name: reg_dump_ctrl

Overview:
- Debug reader for the register file: on a start request it stalls the core, sweeps register addresses through one register-file read channel, and streams each value out on a valid/ready port.
- Sits beside the decode stage and time-shares a read channel via an external mux selected by stall_req.
- Used by the debug/trace unit and by the bench for architectural-state checks.

Parameters:
- ADDR_WIDTH, 5, register address width; matches REG_ADDR_BUS.
- DATA_WIDTH, 32, register data width; matches DATA_BUS.
- NUM_REGS, 32, number of registers swept; must be at most 2^ADDR_WIDTH.
- SKIP_ZERO, 0, if 1 the sweep starts at address 1 (register 0 is constant zero).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle dump request; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word is accepted
- stall_req  out  1  request for the pipeline to freeze and release the read channel
- stall_ack  in  1  pipeline frozen; read channel granted
- read_en  out  1  register-file read enable
- read_addr  out  ADDR_WIDTH  register-file read address
- read_data  in  DATA_WIDTH  register-file read data; combinational, same cycle
- out_valid  out  1  out_data/out_addr/out_last are valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_data  out  DATA_WIDTH  registered register value
- out_addr  out  ADDR_WIDTH  address of out_data
- out_last  out  1  marks the final word of the sweep

Behaviour:
- Reset values: busy, done, stall_req, read_en, out_valid and out_last are 0; read_addr, out_data and out_addr are 0; state is IDLE.
- Reset mid-dump aborts immediately with no done pulse; all outputs return to reset values on the next edge.
- State machine:
  - IDLE: on start, go to REQ and load the address counter with FIRST = SKIP_ZERO ? 1 : 0.
  - REQ: stall_req=1. Wait for stall_ack; when it is high, go to READ. stall_ack is sampled only in REQ.
  - READ: one cycle. read_en=1, read_addr=counter. Capture read_data into out_data and the counter into out_addr; set out_valid=1, with out_last=1 if counter==NUM_REGS-1. Increment the counter, go to SEND.
  - SEND: hold out_* stable while out_valid && !out_ready.
    - On accept with out_last=0: in the same cycle drive read_en=1, read_addr=counter; reload out_*; increment the counter; stay in SEND. Throughput is 1 word/cycle with out_ready held high.
    - On accept with out_last=1: clear out_valid, go to DONE.
  - DONE: done=1 for one cycle; stall_req drops in this cycle; busy drops; go to IDLE.
- read_en is 0 in every cycle except READ and accepting SEND cycles; read_addr holds its last value otherwise.
- stall_req is high in REQ, READ, SEND; it is low in IDLE and DONE.
- Latency with stall_ack already high and out_ready=1:
  - start at cycle T; REQ T+1; READ T+2; first word valid T+3.
  - The last (NUM_REGS-FIRST)-th word is accepted at T+2+(NUM_REGS-FIRST); done one cycle later.
- Simultaneous write: if the core writes the register being read, the register file forwards the write data. The dump captures that value with no special handling.
- start asserted while busy is ignored, with no queuing.
- Counter width is ADDR_WIDTH+1, so the compare at NUM_REGS-1 never wraps.

Decomposition:
- Shared header (bus.v): REG_ADDR_BUS and DATA_BUS widths.
- New dump_defs.v: state encodings IDLE/REQ/READ/SEND/DONE as 3-bit constants.
- No sub-module; a single FSM plus counter plus output register. The read-channel mux belongs to the core top, not this block.

Test Plan:
1. Preload reg i = 0x1000_0000+i; start, stall_ack=1, out_ready=1 -> 32 words on consecutive cycles with out_addr 0..31 and matching data; out_last only on addr 31; done one cycle later; stall_req low after done.
2. SKIP_ZERO=1 with the same preload -> 31 words, first out_addr=1 with data 0x1000_0001, last addr 31.
3. out_ready toggles 1,0,0,1,... -> out_data/out_addr held stable while stalled; no address skipped or duplicated; read_en high only on accept cycles.
4. stall_ack held 0 for 10 cycles after start -> stall_req=1, read_en=0, out_valid=0 throughout; dump proceeds normally once ack rises.
5. Core writes 0xDEADBEEF to reg 7 in the same cycle read_addr=7 -> word with out_addr=7 carries 0xDEADBEEF.
6. rst asserted while out_addr=12 is pending, plus start pulsed during busy -> next edge all outputs reset with no done pulse; the busy-time start has no effect; a new start afterwards performs a full clean dump.

Source files
------------

// File: rtl/reg_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl_pkg
//  Purpose  : Shared widths and state encoding for the register-dump
//             controller.
//  Contents : REG_ADDR_BUS / DATA_BUS bus widths and the 3-bit FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_dump_ctrl_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int DATA_BUS     = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl
//  Purpose  : Debug reader for the register file. On start it requests a
//             pipeline stall, then sweeps register addresses through one
//             read channel and streams each value out on a valid/ready port.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start             - one-cycle dump request (accepted in idle)
//             busy, done        - sweep in progress / one-cycle completion
//             stall_req/ack     - pipeline freeze handshake
//             read_en/addr/data - register-file read channel (comb. data)
//             out_valid/ready   - output handshake
//             out_data/addr/last- registered word, its address, final flag
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int NUM_REGS   = 32,
  parameter int SKIP_ZERO  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  stall_req,
  input  logic                  stall_ack,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);

  // One extra counter bit so the increment past the last register never
  // wraps back onto a valid address.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FIRST = (SKIP_ZERO != 0) ? CNT_W'(1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_REGS - 1);

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  stall_req_q, stall_req_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic                  accept;

  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    read_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          cnt_d   = FIRST;
        end
      end
      S_REQ: begin
        if (stall_ack) state_d = S_READ;
      end
      S_READ: begin
        read_en = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            // Refill the output register in the same cycle it drains.
            read_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is combinational, so the word is captured in the cycle
    // the address is presented.
    if (read_en) begin
      out_data_d  = read_data;
      out_addr_d  = cnt_q[ADDR_WIDTH-1:0];
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == LAST);
      last_addr_d = cnt_q[ADDR_WIDTH-1:0];
      cnt_d       = cnt_q + CNT_W'(1);
    end

    busy_d      = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_SEND);
    stall_req_d = busy_d;
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_req_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_req_q <= stall_req_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // Outside read cycles the address bus holds the last address issued.
  assign read_addr = read_en ? cnt_q[ADDR_WIDTH-1:0] : last_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stall_req = stall_req_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule
`default_nettype wire
